// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-oriented SPI mode 0 master, MSB first
//
// Purpose: shifts one byte out on MOSI while capturing one byte from MISO,
//   with a programmable SSEL setup/hold window and an idle gap between frames.
//   Optional feature macro: SPI_MASTER_BURST_EN (back-to-back bytes in one SSEL frame).
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tx_valid/tx_ready   byte handshake, tx_data is the byte to send
//   rx_valid, rx_data   one-cycle pulse with the received byte (rx_data held)
//   busy                transfer in progress (including the idle gap)
//   SCK, MOSI, SSEL     SPI outputs (SCK idles low, SSEL active low)
//   MISO                SPI input, 2-flop synchronized
module spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int SSEL_SETUP = 8,
  parameter int SSEL_HOLD  = 8,
  parameter int IDLE_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be >= 4");
  end

  localparam int MAX_A = (CLK_DIV > SSEL_SETUP) ? CLK_DIV : SSEL_SETUP;
  localparam int MAX_B = (SSEL_HOLD > IDLE_GAP) ? SSEL_HOLD : IDLE_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    tx_shift, rx_shift;
  logic          miso_meta, miso_s;
  logic          load_tx, shift_tx, sample_rx, finish, burst_done;
  logic          frame_active;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = (cnt != '0) ? cnt - 1'b1 : cnt;
    bit_cnt_n  = bit_cnt;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    sample_rx  = 1'b0;
    finish     = 1'b0;
    burst_done = 1'b0;
    tx_ready   = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          state_n   = SETUP;
          cnt_n     = CW'(SSEL_SETUP - 1);
          bit_cnt_n = 3'd7;
          load_tx   = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = SHIFT_LO;
          cnt_n   = CW'(CLK_DIV - 1);
        end
      end
      SHIFT_LO: begin
        if (cnt == '0) begin
          state_n = SHIFT_HI;
          cnt_n   = CW'(CLK_DIV - 1);
        end
      end
      SHIFT_HI: begin
        if (cnt == '0) begin
          sample_rx = 1'b1;
          if (bit_cnt == 3'd0) begin
            state_n = HOLD;
            cnt_n   = CW'(SSEL_HOLD - 1);
`ifdef SPI_MASTER_BURST_EN
            // Chain the next byte into the same frame instead of closing it.
            tx_ready = 1'b1;
            if (tx_valid) begin
              state_n    = SHIFT_LO;
              cnt_n      = CW'(CLK_DIV - 1);
              bit_cnt_n  = 3'd7;
              load_tx    = 1'b1;
              burst_done = 1'b1;
            end
`endif
          end else begin
            state_n   = SHIFT_LO;
            cnt_n     = CW'(CLK_DIV - 1);
            bit_cnt_n = bit_cnt - 3'd1;
            shift_tx  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = CW'(IDLE_GAP - 1);
          finish  = 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are forced to their idle values on every reset cycle.
    if (rst) tx_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      miso_meta <= MISO;
      miso_s    <= miso_meta;
      rx_valid  <= 1'b0;
      if (load_tx)       tx_shift <= tx_data;
      else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};
      if (sample_rx) rx_shift <= {rx_shift[6:0], miso_s};
      if (finish) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
      // In a burst the last bit is sampled on this same edge, so merge it here.
      if (burst_done) begin
        rx_data  <= {rx_shift[6:0], miso_s};
        rx_valid <= 1'b1;
      end
    end
  end

  assign frame_active = (state == SETUP) || (state == SHIFT_LO) ||
                        (state == SHIFT_HI) || (state == HOLD);

  assign SCK  = !rst && (state == SHIFT_HI);
  assign SSEL = rst || !frame_active;
  assign MOSI = !rst && frame_active && tx_shift[7];
  assign busy = !rst && (state != IDLE);

endmodule
